t01_ai_move_sequencer: RTL and testbench

- Sits between the AI inference pipeline and the tetris game FSM.
- On each new piece, pulses the AI start and waits for its done signal. It then decodes the recommended move ID into a rotation count and a target column.
- Replays that move into the FSM as spaced single-cycle rotate/left/right pulses.
- Arbitrates the FSM control inputs: debounced human buttons pass through when AI mode is off and are blocked when it is on.

---
 rtl/t01_ai_pkg.sv | 24 ++
 rtl/t01_move_decode.sv | 31 +++
 rtl/t01_ai_move_sequencer.sv | 156 +++++++++++++++
 tb/tb_t01_ai_move_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/t01_ai_pkg.sv
// Shared types and constants for the AI move sequencer and the move decoder.
`timescale 1ns/1ps
package t01_ai_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_AI = 3'd2,
    DECODE  = 3'd3,
    ROTATE  = 3'd4,
    SHIFT   = 3'd5,
    HOLD    = 3'd6
  } state_t;

  localparam int BOARD_COLS  = 10;
  localparam int NUM_ROT     = 4;
  localparam int MAX_MOVE_ID = NUM_ROT * BOARD_COLS;

  typedef struct packed {
    logic [1:0] rot;
    logic [3:0] col;
  } move_t;

endpackage

// File: rtl/t01_move_decode.sv
// Splits a move ID into rotation (id/10) and column (id%10) using a compare chain.
`timescale 1ns/1ps
module t01_move_decode
  import t01_ai_pkg::*;
(
  input  logic [5:0] move_id,
  output move_t      move,
  output logic       invalid
);

  always_comb begin
    move    = '0;
    invalid = 1'b0;
    if (move_id >= 6'(MAX_MOVE_ID)) begin
      invalid = 1'b1;
    end else if (move_id >= 6'(3 * BOARD_COLS)) begin
      move.rot = 2'd3;
      move.col = 4'(move_id - 6'(3 * BOARD_COLS));
    end else if (move_id >= 6'(2 * BOARD_COLS)) begin
      move.rot = 2'd2;
      move.col = 4'(move_id - 6'(2 * BOARD_COLS));
    end else if (move_id >= 6'(BOARD_COLS)) begin
      move.rot = 2'd1;
      move.col = 4'(move_id - 6'(BOARD_COLS));
    end else begin
      move.rot = 2'd0;
      move.col = move_id[3:0];
    end
  end

endmodule

// File: rtl/t01_ai_move_sequencer.sv
// Requests an AI move per spawned piece and replays it as spaced rotate/shift pulses;
// human buttons pass through (registered) whenever AI mode is off.
`timescale 1ns/1ps
module t01_ai_move_sequencer
  import t01_ai_pkg::*;
#(
  parameter int SPAWN_COL  = 3,
  parameter int STEP_GAP   = 16,
  parameter int AI_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ai_enable,
  input  logic       piece_spawn,
  input  logic       ai_done,
  input  logic [5:0] ai_best_move_id,
  input  logic       right_i,
  input  logic       left_i,
  input  logic       rotate_r_i,
  input  logic       rotate_l_i,
  output logic       start_ai,
  output logic       right_o,
  output logic       left_o,
  output logic       rotate_r_o,
  output logic       rotate_l_o,
  output logic       busy,
  output logic       err_invalid,
  output logic       err_timeout,
  output logic [2:0] state_o
);

  localparam int GW = $clog2(STEP_GAP);
  localparam int TW = $clog2(AI_TIMEOUT);

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gap;
  logic [5:0]      move_id;
  logic [1:0]      rot_left;
  logic            rot_ccw;
  logic [3:0]      shift_left;
  logic            shift_neg;
  move_t           dec_move;
  logic            dec_invalid;
  logic [4:0]      delta;
  logic [3:0]      delta_mag;

  t01_move_decode u_decode (
    .move_id (move_id),
    .move    (dec_move),
    .invalid (dec_invalid)
  );

  assign delta     = 5'({1'b0, dec_move.col}) - 5'(SPAWN_COL);
  assign delta_mag = delta[4] ? 4'(-delta) : delta[3:0];
  assign busy      = (state != IDLE);
  assign state_o   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      gap         <= '0;
      move_id     <= '0;
      rot_left    <= '0;
      rot_ccw     <= 1'b0;
      shift_left  <= '0;
      shift_neg   <= 1'b0;
      start_ai    <= 1'b0;
      right_o     <= 1'b0;
      left_o      <= 1'b0;
      rotate_r_o  <= 1'b0;
      rotate_l_o  <= 1'b0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      start_ai   <= 1'b0;
      right_o    <= 1'b0;
      left_o     <= 1'b0;
      rotate_r_o <= 1'b0;
      rotate_l_o <= 1'b0;
      if (!ai_enable) begin
        state      <= IDLE;
        right_o    <= right_i;
        left_o     <= left_i;
        rotate_r_o <= rotate_r_i;
        rotate_l_o <= rotate_l_i;
      end else if (piece_spawn) begin
        // A new piece always restarts the request, abandoning any move in flight.
        state    <= REQ;
        start_ai <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          REQ: begin
            tcnt  <= '0;
            state <= WAIT_AI;
          end
          WAIT_AI: begin
            if (ai_done) begin
              move_id <= ai_best_move_id;
              state   <= DECODE;
            end else if (tcnt == TW'(AI_TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              state       <= HOLD;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          DECODE: begin
            if (dec_invalid) begin
              err_invalid <= 1'b1;
              state       <= HOLD;
            end else begin
              // Three clockwise turns are replayed as a single counter-clockwise turn.
              rot_left   <= (dec_move.rot == 2'd3) ? 2'd1 : dec_move.rot;
              rot_ccw    <= (dec_move.rot == 2'd3);
              shift_left <= delta_mag;
              shift_neg  <= delta[4];
              gap        <= '0;
              state      <= ROTATE;
            end
          end
          ROTATE: begin
            if (rot_left == 2'd0) begin
              state <= SHIFT;
              if (gap != '0) gap <= gap - GW'(1);
            end else if (gap == '0) begin
              rotate_l_o <= rot_ccw;
              rotate_r_o <= !rot_ccw;
              rot_left   <= rot_left - 2'd1;
              gap        <= GW'(STEP_GAP - 1);
            end else begin
              gap <= gap - GW'(1);
            end
          end
          SHIFT: begin
            if (shift_left == 4'd0) begin
              state <= HOLD;
            end else if (gap == '0) begin
              left_o     <= shift_neg;
              right_o    <= !shift_neg;
              shift_left <= shift_left - 4'd1;
              gap        <= GW'(STEP_GAP - 1);
            end else begin
              gap <= gap - GW'(1);
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t01_ai_move_sequencer.sv
// Directed bench for the AI move sequencer: passthrough, move replay, errors and aborts.
`timescale 1ns/1ps
module tb_t01_ai_move_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ai_enable;
  logic       piece_spawn;
  logic       ai_done;
  logic [5:0] ai_best_move_id;
  logic       right_i, left_i, rotate_r_i, rotate_l_i;
  logic       start_ai, right_o, left_o, rotate_r_o, rotate_l_o;
  logic       busy, err_invalid, err_timeout;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int multi_hot = 0;
  int ev_kind[$];
  int ev_cyc[$];
  int exp_q[$];

  t01_ai_move_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .ai_enable       (ai_enable),
    .piece_spawn     (piece_spawn),
    .ai_done         (ai_done),
    .ai_best_move_id (ai_best_move_id),
    .right_i         (right_i),
    .left_i          (left_i),
    .rotate_r_i      (rotate_r_i),
    .rotate_l_i      (rotate_l_i),
    .start_ai        (start_ai),
    .right_o         (right_o),
    .left_o          (left_o),
    .rotate_r_o      (rotate_r_o),
    .rotate_l_o      (rotate_l_o),
    .busy            (busy),
    .err_invalid     (err_invalid),
    .err_timeout     (err_timeout),
    .state_o         (state_o)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Command log: 0=rotate_r, 1=rotate_l, 2=right, 3=left, stamped with the cycle seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (rotate_r_o) begin ev_kind.push_back(0); ev_cyc.push_back(cyc); end
      if (rotate_l_o) begin ev_kind.push_back(1); ev_cyc.push_back(cyc); end
      if (right_o)    begin ev_kind.push_back(2); ev_cyc.push_back(cyc); end
      if (left_o)     begin ev_kind.push_back(3); ev_cyc.push_back(cyc); end
      if (int'(rotate_r_o) + int'(rotate_l_o) + int'(right_o) + int'(left_o) > 1) multi_hot++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic pulseSpawn();
    piece_spawn = 1'b1;
    @(negedge clk);
    piece_spawn = 1'b0;
  endtask

  task automatic waitStart(input string tag, input int budget);
    int  n = 0;
    bit  seen;
    seen = start_ai;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = start_ai;
    end
    ai_done = 1'b0;
    checkOutput(tag, 32'(seen), 1);
  endtask

  task automatic applyStimulus(input logic [5:0] id);
    repeat (50) @(negedge clk);
    ai_best_move_id = id;
    ai_done         = 1'b1;
  endtask

  task automatic waitState(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (state_o !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(state_o), 32'(s));
  endtask

  task automatic waitRightPulse(input string tag, input int budget);
    int n = 0;
    while (right_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(right_o), 1);
  endtask

  task automatic checkSequence(input string tag, input int t0, input int expk[$]);
    int k[$];
    int c[$];
    foreach (ev_kind[i]) begin
      if (ev_cyc[i] >= t0) begin
        k.push_back(ev_kind[i]);
        c.push_back(ev_cyc[i]);
      end
    end
    checkOutput({tag, " count"}, 32'(k.size()), 32'(expk.size()));
    for (int i = 0; i < expk.size() && i < k.size(); i++) begin
      checkOutput($sformatf("%s kind%0d", tag, i), 32'(k[i]), 32'(expk[i]));
      if (i > 0) checkOutput($sformatf("%s spacing%0d", tag, i), 32'(c[i] - c[i-1]), 16);
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; ai_enable = 1'b0; piece_spawn = 1'b0; ai_done = 1'b0;
    ai_best_move_id = '0;
    right_i = 1'b0; left_i = 1'b0; rotate_r_i = 1'b0; rotate_l_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset state", 32'(state_o), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset start_ai", 32'(start_ai), 0);
    checkOutput("reset err_invalid", 32'(err_invalid), 0);
    checkOutput("reset err_timeout", 32'(err_timeout), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] human passthrough");
    right_i = 1'b1;
    @(negedge clk);
    right_i = 1'b0;
    checkOutput("pass right_o", 32'(right_o), 1);
    checkOutput("pass start_ai", 32'(start_ai), 0);
    @(negedge clk);
    checkOutput("pass right_o off", 32'(right_o), 0);
    pulseSpawn();
    checkOutput("manual spawn start_ai", 32'(start_ai), 0);
    checkOutput("manual spawn state", 32'(state_o), 0);

    $display("[TB] move 25");
    ai_enable = 1'b1;
    @(negedge clk);
    t0 = cyc;
    pulseSpawn();
    waitStart("id25 start", 8);
    applyStimulus(6'd25);
    waitState("id25 hold", 3'd6, 400);
    exp_q = {0, 0, 2, 2};
    checkSequence("id25", t0, exp_q);
    checkOutput("id25 busy", 32'(busy), 1);

    $display("[TB] move 30");
    t0 = cyc;
    pulseSpawn();
    waitStart("id30 start", 8);
    applyStimulus(6'd30);
    waitState("id30 hold", 3'd6, 400);
    exp_q = {1, 3, 3, 3};
    checkSequence("id30", t0, exp_q);

    $display("[TB] move 45");
    t0 = cyc;
    pulseSpawn();
    waitStart("id45 start", 8);
    applyStimulus(6'd45);
    waitState("id45 hold", 3'd6, 50);
    repeat (20) @(negedge clk);
    exp_q.delete();
    checkSequence("id45", t0, exp_q);
    checkOutput("id45 err_invalid", 32'(err_invalid), 1);
    checkOutput("id45 err_timeout", 32'(err_timeout), 0);

    $display("[TB] timeout");
    pulseSpawn();
    waitStart("tmo start", 8);
    repeat (4090) @(negedge clk);
    checkOutput("tmo early err", 32'(err_timeout), 0);
    checkOutput("tmo early state", 32'(state_o), 2);
    repeat (10) @(negedge clk);
    checkOutput("tmo err", 32'(err_timeout), 1);
    checkOutput("tmo state", 32'(state_o), 6);
    checkOutput("tmo invalid sticky", 32'(err_invalid), 1);
    pulseSpawn();
    checkOutput("tmo respawn start_ai", 32'(start_ai), 1);
    ai_done = 1'b0;

    $display("[TB] abort by spawn mid-shift");
    applyStimulus(6'd29);
    waitRightPulse("abort first right", 300);
    pulseSpawn();
    t0 = cyc;
    checkOutput("abort start_ai", 32'(start_ai), 1);
    ai_done = 1'b0;
    repeat (60) @(negedge clk);
    exp_q.delete();
    checkSequence("abort", t0, exp_q);
    checkOutput("abort state", 32'(state_o), 2);

    $display("[TB] abort by ai_enable drop mid-shift");
    applyStimulus(6'd29);
    waitRightPulse("drop first right", 300);
    ai_enable = 1'b0;
    @(negedge clk);
    checkOutput("drop state", 32'(state_o), 0);
    checkOutput("drop busy", 32'(busy), 0);
    t0 = cyc;
    left_i = 1'b1;
    @(negedge clk);
    left_i = 1'b0;
    checkOutput("drop left_o", 32'(left_o), 1);
    repeat (40) @(negedge clk);
    exp_q = {3};
    checkSequence("drop", t0, exp_q);

    checkOutput("single command per cycle", 32'(multi_hot), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
